// File: rtl/dff_share_arb.sv
// Round-robin arbiter that sequences every load of one shared capture register.
// The winner's data is captured one cycle after grant and held for HOLD_CYCLES cycles.
module dff_share_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 2,
  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [OW-1:0]            dout_owner,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

  state_e               state_q;
  logic [OW-1:0]        ptr_q;
  logic [OW-1:0]        w_q;
  logic [CW-1:0]        cnt_q;
  logic [OW-1:0]        pick;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [OW-1:0]        ptr_next;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic          found;
    int unsigned   idx;
    logic [OW-1:0] cand;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(ptr_q) + k) % NUM_REQ;
      cand = OW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    gnt_d[pick] = 1'b1;
  end

  assign ptr_next = (w_q == OW'(NUM_REQ - 1)) ? '0 : w_q + 1'b1;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      gnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_owner <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            w_q     <= pick;
            gnt     <= gnt_d;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          // Captures even if the winner withdrew req during this cycle.
          dout       <= din[int'(w_q)*WIDTH +: WIDTH];
          dout_valid <= 1'b1;
          dout_owner <= w_q;
          cnt_q      <= CW'(HOLD_CYCLES - 1);
          gnt        <= '0;
          state_q    <= StHold;
        end
        StHold: begin
          if (cnt_q == '0) begin
            dout_valid <= 1'b0;
            ptr_q      <= ptr_next;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench for dff_share_arb (NUM_REQ=4, WIDTH=8, HOLD_CYCLES=2): a vector table of
// whole grant transactions plus hand-written reset and idle sequences.
module tb_dff_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [1:0]  dout_owner;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_e0 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dff_share_arb #(
    .NUM_REQ    (4),
    .WIDTH      (8),
    .HOLD_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_owner(dout_owner),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]  r_start;  // req before the sampling edge
    logic [3:0]  r_grant;  // req during GRANT
    logic [3:0]  r_hold1;  // req during first HOLD cycle
    logic [3:0]  r_hold2;  // req during second HOLD cycle
    logic [31:0] data;
    logic [1:0]  owner;
    logic [7:0]  value;
    bit          chk_gap;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t       v;
    logic [3:0] one;
    v   = tbl[i];
    one = 4'b0001 << v.owner;
    din = v.data;
    req = v.r_start;
    step();  // E0
    chk($sformatf("v%0d e0 gnt", i), 32'(gnt), 32'(one));
    chk($sformatf("v%0d e0 busy", i), 32'(busy), 32'd1);
    chk($sformatf("v%0d e0 valid", i), 32'(dout_valid), 32'd0);
    if (v.chk_gap) chk($sformatf("v%0d grant spacing", i), 32'(cyc - last_e0), 32'd4);
    last_e0 = cyc;
    req = v.r_grant;
    step();  // E1
    chk($sformatf("v%0d e1 gnt", i), 32'(gnt), 32'd0);
    chk($sformatf("v%0d e1 dout", i), 32'(dout), 32'(v.value));
    chk($sformatf("v%0d e1 owner", i), 32'(dout_owner), 32'(v.owner));
    chk($sformatf("v%0d e1 valid", i), 32'(dout_valid), 32'd1);
    req = v.r_hold1;
    step();  // E2
    chk($sformatf("v%0d e2 gnt", i), 32'(gnt), 32'd0);
    chk($sformatf("v%0d e2 dout", i), 32'(dout), 32'(v.value));
    chk($sformatf("v%0d e2 valid", i), 32'(dout_valid), 32'd1);
    chk($sformatf("v%0d e2 busy", i), 32'(busy), 32'd1);
    req = v.r_hold2;
    step();  // E3
    chk($sformatf("v%0d e3 valid", i), 32'(dout_valid), 32'd0);
    chk($sformatf("v%0d e3 busy", i), 32'(busy), 32'd0);
    chk($sformatf("v%0d e3 dout kept", i), 32'(dout), 32'(v.value));
    chk($sformatf("v%0d e3 owner kept", i), 32'(dout_owner), 32'(v.owner));
  endtask

  initial begin
    // Fairness with all requesting, ptr starting at 0.
    tbl[0]  = '{4'hF, 4'hF, 4'hF, 4'hF, 32'h13121110, 2'd0, 8'h10, 1'b0};
    tbl[1]  = '{4'hF, 4'hF, 4'hF, 4'hF, 32'h13121110, 2'd1, 8'h11, 1'b1};
    tbl[2]  = '{4'hF, 4'hF, 4'hF, 4'hF, 32'h13121110, 2'd2, 8'h12, 1'b1};
    tbl[3]  = '{4'hF, 4'hF, 4'hF, 4'hF, 32'h13121110, 2'd3, 8'h13, 1'b1};
    // Owner 0 again; req[2] pulses during HOLD and must be ignored.
    tbl[4]  = '{4'hF, 4'hF, 4'h4, 4'h0, 32'h13121110, 2'd0, 8'h10, 1'b1};
    // Make owner 3 the last winner, then wrap-around skip with 1010.
    tbl[5]  = '{4'h8, 4'h8, 4'h0, 4'h0, 32'h13121110, 2'd3, 8'h13, 1'b0};
    tbl[6]  = '{4'hA, 4'hA, 4'hA, 4'hA, 32'h13121110, 2'd1, 8'h11, 1'b1};
    tbl[7]  = '{4'hA, 4'hA, 4'hA, 4'hA, 32'h13121110, 2'd3, 8'h13, 1'b1};
    tbl[8]  = '{4'hA, 4'hA, 4'hA, 4'h0, 32'h13121110, 2'd1, 8'h11, 1'b1};
    // Single request (ptr=2 scans 2,3,0,1).
    tbl[9]  = '{4'h2, 4'h2, 4'h0, 4'h0, 32'h00003C00, 2'd1, 8'h3C, 1'b1};
    // Winner withdraws req during GRANT; capture still happens.
    tbl[10] = '{4'h1, 4'h0, 4'h0, 4'h0, 32'h00000077, 2'd0, 8'h77, 1'b1};
    // First grant after the mid-HOLD reset.
    tbl[11] = '{4'h4, 4'h4, 4'h0, 4'h0, 32'h00A50000, 2'd2, 8'hA5, 1'b0};

    rst = 1'b0;
    req = 4'h0;
    din = 32'h0;
    #1;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset valid", 32'(dout_valid), 32'd0);
    chk("reset owner", 32'(dout_owner), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i <= 4; i++) run_vec(i);

    // After the ignored req[2] pulse with req=0, the block must stay idle.
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("idle%0d gnt", k), 32'(gnt), 32'd0);
      chk($sformatf("idle%0d busy", k), 32'(busy), 32'd0);
      chk($sformatf("idle%0d dout", k), 32'(dout), 32'h10);
    end

    for (int i = 5; i <= 10; i++) run_vec(i);

    // Reset in the middle of HOLD with dout=A5 (ptr=1 so 0100 wins requester 2).
    din = 32'h00A50000;
    req = 4'h4;
    step();
    chk("rsthold e0 gnt", 32'(gnt), 32'h4);
    req = 4'h0;
    step();
    chk("rsthold e1 dout", 32'(dout), 32'hA5);
    step();
    chk("rsthold e2 valid", 32'(dout_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async rst gnt", 32'(gnt), 32'd0);
    chk("async rst dout", 32'(dout), 32'd0);
    chk("async rst valid", 32'(dout_valid), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst owner", 32'(dout_owner), 32'd0);
    #2 rst = 1'b1;
    run_vec(11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
